// File: rtl/conv_result_checker_pkg.sv
// Shared defaults, channel-select codes and FSM states for the CONV write-port checker.
package conv_pkg;
  localparam int DEF_DATA_W = 20;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_SEL_W  = 3;
  localparam int DEF_CNT_W  = 13;

  localparam logic [DEF_SEL_W-1:0] CSEL_L0K0 = 3'd1;
  localparam logic [DEF_SEL_W-1:0] CSEL_L0K1 = 3'd2;
  localparam logic [DEF_SEL_W-1:0] CSEL_L1K0 = 3'd3;
  localparam logic [DEF_SEL_W-1:0] CSEL_L1K1 = 3'd4;
  localparam logic [DEF_SEL_W-1:0] CSEL_L2   = 3'd5;
  localparam int DEF_NUM_CH = int'(CSEL_L2);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} conv_st_e;
endpackage

// File: rtl/conv_result_checker_if.sv
// CONV write port plus golden-memory read port as seen by the checker.
interface conv_result_checker_if import conv_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SEL_W  = DEF_SEL_W
);
  logic              cwr;
  logic [SEL_W-1:0]  csel;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              exp_rd;
  logic [SEL_W-1:0]  exp_sel;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;

  modport master (output cwr, csel, caddr_wr, cdata_wr, exp_data,
                  input  exp_rd, exp_sel, exp_addr);
  modport slave  (input  cwr, csel, caddr_wr, cdata_wr, exp_data,
                  output exp_rd, exp_sel, exp_addr);
endinterface

// File: rtl/conv_result_checker_tol_cmp.sv
// Modular tolerance compare: match when (a - b) mod 2^DATA_W lies within +/-TOL of zero.
module conv_tol_cmp #(
  parameter int DATA_W = 20,
  parameter int TOL    = 0
)(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_match
);
  // One extra bit so that TOL=0 puts the upper limit out of reach.
  localparam logic [DATA_W:0] LIM_LO = (DATA_W+1)'(TOL);
  localparam logic [DATA_W:0] LIM_HI = {1'b1, {DATA_W{1'b0}}} - LIM_LO;

  logic [DATA_W-1:0] w_d;
  assign w_d     = i_a - i_b;
  assign o_match = ({1'b0, w_d} <= LIM_LO) || ({1'b0, w_d} >= LIM_HI);
endmodule

// File: rtl/conv_result_checker.sv
// On-line checker for the CONV write port: golden compare, per-channel counters, first-error latch, done/pass.
module conv_result_checker import conv_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TOL    = 0
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    busy,
  conv_result_checker_if.slave    bus,
  input  logic [NUM_CH*CNT_W-1:0] ch_len,
  output logic [NUM_CH*CNT_W-1:0] wr_cnt,
  output logic [NUM_CH*CNT_W-1:0] err_cnt,
  output logic                    first_err,
  output logic [SEL_W-1:0]        ferr_sel,
  output logic [ADDR_W-1:0]       ferr_addr,
  output logic                    late_wr,
  output logic                    done,
  output logic                    pass
);
  conv_st_e          r_st;
  logic              r_drain;
  logic              r_done, r_late;
  logic              r_s1_vld;
  logic [SEL_W-1:0]  r_s1_sel;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_first_err;
  logic [SEL_W-1:0]  r_ferr_sel;
  logic [ADDR_W-1:0] r_ferr_addr;
  logic              w_wr_vld, w_match, w_mis;
  logic [NUM_CH-1:0] w_ch_ok;

  assign w_wr_vld     = bus.cwr && (bus.csel != '0) && (bus.csel <= SEL_W'(NUM_CH));
  assign bus.exp_rd   = w_wr_vld && !reset;
  assign bus.exp_sel  = bus.csel;
  assign bus.exp_addr = bus.caddr_wr;

  conv_tol_cmp #(.DATA_W(DATA_W), .TOL(TOL)) u_cmp (
    .i_a(r_s1_data), .i_b(bus.exp_data), .o_match(w_match)
  );
  assign w_mis = r_s1_vld && !w_match;

  // S1 lines the write up with the golden word, which returns one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_sel  <= '0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld  <= w_wr_vld && (r_st != ST_DONE);
      r_s1_sel  <= bus.csel;
      r_s1_addr <= bus.caddr_wr;
      r_s1_data <= bus.cdata_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_first_err <= 1'b0;
      r_ferr_sel  <= '0;
      r_ferr_addr <= '0;
    end else if (w_mis && !r_first_err) begin
      r_first_err <= 1'b1;
      r_ferr_sel  <= r_s1_sel;
      r_ferr_addr <= r_s1_addr;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_wr, r_err;
    logic [CNT_W-1:0] w_len;
    logic             w_hit;
    assign w_len = ch_len[c*CNT_W +: CNT_W];
    assign w_hit = r_s1_vld && (r_s1_sel == SEL_W'(c+1));
    always_ff @(posedge clk) begin
      if (reset) begin
        r_wr  <= '0;
        r_err <= '0;
      end else if (w_hit) begin
        if (r_wr != '1)              r_wr  <= r_wr + 1'b1;
        if (!w_match && r_err != '1) r_err <= r_err + 1'b1;
      end
    end
    assign wr_cnt[c*CNT_W +: CNT_W]  = r_wr;
    assign err_cnt[c*CNT_W +: CNT_W] = r_err;
    assign w_ch_ok[c] = (r_err == '0) && ((w_len == '0) || (r_wr == w_len));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st    <= ST_IDLE;
      r_drain <= 1'b0;
      r_done  <= 1'b0;
      r_late  <= 1'b0;
    end else begin
      case (r_st)
        ST_IDLE:  if (busy) r_st <= ST_RUN;
        ST_RUN:   if (!busy) begin
                    r_st    <= ST_DRAIN;
                    r_drain <= 1'b0;
                  end
        ST_DRAIN: if (r_drain) begin
                    r_st   <= ST_DONE;
                    r_done <= 1'b1;
                  end else begin
                    r_drain <= 1'b1;
                  end
        ST_DONE:  if (w_wr_vld) r_late <= 1'b1;
        default:  r_st <= ST_IDLE;
      endcase
    end
  end

  assign first_err = r_first_err;
  assign ferr_sel  = r_ferr_sel;
  assign ferr_addr = r_ferr_addr;
  assign late_wr   = r_late;
  assign done      = r_done;
  assign pass      = r_done && (&w_ch_ok);
endmodule
